stream_demux_reg: RTL and testbench

- Registered, flow-controlled successor to the recursive combinational demux.
- Routes one T-bit input word to one of 2^S output channels selected by ctrl, or to all channels in broadcast mode.
- Each output channel has a one-entry holding register with a valid/ready handshake, so the block can sit between pipelined producers and independent consumers.
- Placed in the routing library. It is the clocked front end for per-lane fan-out.

---
 rtl/stream_demux_reg_if.sv | 30 +++
 rtl/stream_demux_reg.sv | 67 ++++++
 tb/tb_stream_demux_reg.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_reg_if.sv
// Handshake bundle for stream_demux_reg: one producer-side stream in,
// N independent valid/ready channels out (channel k at out[(k+1)*T-1 : k*T]).
interface stream_demux_reg_if #(
    parameter int S = 3,
    parameter int T = 8
);
    localparam int N = 1 << S;

    logic [T-1:0]   in;
    logic [S-1:0]   ctrl;
    logic           bcast;
    logic           in_valid;
    logic           in_ready;
    logic [N*T-1:0] out;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;
    logic           busy;

    // Environment view: drives the producer stream and the consumer readies.
    modport master (
        output in, ctrl, bcast, in_valid, out_ready,
        input  in_ready, out, out_valid, busy
    );

    // Demux view.
    modport slave (
        input  in, ctrl, bcast, in_valid, out_ready,
        output in_ready, out, out_valid, busy
    );
endinterface

// File: rtl/stream_demux_reg.sv
// Registered stream demux: routes one T-bit word to channel ctrl (or to all
// 2^S channels on bcast) through a one-entry valid/ready register per channel.
module stream_demux_reg #(
    parameter int S = 3,
    parameter int T = 8
) (
    input logic               clk,
    input logic               rst_n,
    stream_demux_reg_if.slave bus
);
    localparam int N = 1 << S;

    logic [N-1:0]        valid_q;
    logic [N-1:0][T-1:0] data_q;
    logic [N-1:0]        free;
    logic [N-1:0]        sel;
    logic [N-1:0]        load;
    logic                accept;

    // A channel draining this cycle counts as free, so it can be refilled
    // on the same edge without a bubble.
    assign free = ~valid_q | bus.out_ready;

    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // skipped an assignment would infer a latch.
        sel = '0;
        if (bus.bcast) begin
            sel = '1;
        end else begin
            sel[bus.ctrl] = 1'b1;
        end
    end

    // Broadcast is all-or-nothing; in_ready never looks at in_valid.
    assign bus.in_ready = bus.bcast ? &free : free[bus.ctrl];
    assign accept       = bus.in_valid & bus.in_ready;
    assign load         = accept ? sel : '0;

    for (genvar k = 0; k < N; k++) begin : g_ch
        logic         valid_r;
        logic [T-1:0] data_r;

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_r <= 1'b0;
                // NOTE: the data register is reset too, because out must read
                // zero while rst_n is low, not just out_valid.
                data_r  <= '0;
            end else if (load[k]) begin
                valid_r <= 1'b1;
                data_r  <= bus.in;
            end else if (bus.out_ready[k]) begin
                valid_r <= 1'b0;
            end
        end

        assign valid_q[k] = valid_r;
        assign data_q[k]  = data_r;
    end

    assign bus.out       = data_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = |valid_q;
endmodule

// File: tb/tb_stream_demux_reg.sv
// Bench for stream_demux_reg: vector table plus directed sequences on S=3/T=8,
// and a randomised S=1/T=1 run, with per-channel scoreboards on both.
module tb_stream_demux_reg;
    typedef struct {
        logic       in_valid;
        logic       bcast;
        logic [2:0] ctrl;
        logic [7:0] data;
        logic [7:0] out_ready;
        logic       exp_ready;
        logic [7:0] exp_valid;
        int         lane;
        logic [7:0] lane_val;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    stream_demux_reg_if #(.S(3), .T(8)) m_if ();
    stream_demux_reg_if #(.S(1), .T(1)) e_if ();

    stream_demux_reg #(.S(3), .T(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if.slave)
    );

    stream_demux_reg #(.S(1), .T(1)) u_dut_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (e_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboards: push on accept, pop on drain; both observed at negedge.
    logic [7:0] mq [8][$];
    logic       eq [2][$];
    logic       e_acc = 1'b0;

    always @(negedge clk) begin : mon_main
        logic [7:0] e;
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) mq[k].delete();
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (m_if.out_valid[k] && m_if.out_ready[k]) begin
                    check($sformatf("m_sb_expected_ch%0d", k), mq[k].size() != 0, 1);
                    if (mq[k].size() != 0) begin
                        e = mq[k].pop_front();
                        check($sformatf("m_sb_data_ch%0d", k), m_if.out[k*8 +: 8], e);
                    end
                end
            end
            if (m_if.in_valid && m_if.in_ready) begin
                for (int k = 0; k < 8; k++)
                    if (m_if.bcast || m_if.ctrl == 3'(k)) mq[k].push_back(m_if.in);
            end
        end
    end

    always @(negedge clk) begin : mon_edge
        logic e;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) eq[k].delete();
            e_acc = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (e_if.out_valid[k] && e_if.out_ready[k]) begin
                    check($sformatf("e_sb_expected_ch%0d", k), eq[k].size() != 0, 1);
                    if (eq[k].size() != 0) begin
                        e = eq[k].pop_front();
                        check($sformatf("e_sb_data_ch%0d", k), e_if.out[k], e);
                    end
                end
            end
            e_acc = e_if.in_valid & e_if.in_ready;
            if (e_acc) begin
                for (int k = 0; k < 2; k++)
                    if (e_if.bcast || e_if.ctrl == 1'(k)) eq[k].push_back(e_if.in[0]);
            end
        end
    end

    vec_t vecs[14];
    logic e_pend;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 3'd3, 8'hA5, 8'hFF, 1'b1, 8'h00, -1, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h08,  3, 8'hA5};
        vecs[2]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, -1, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 3'd6, 8'h11, 8'hBF, 1'b1, 8'h00, -1, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 3'd6, 8'h22, 8'hBF, 1'b0, 8'h40,  6, 8'h11};
        vecs[5]  = '{1'b1, 1'b0, 3'd6, 8'h22, 8'hFF, 1'b1, 8'h40,  6, 8'h11};
        vecs[6]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hBF, 1'b1, 8'h40,  6, 8'h22};
        vecs[7]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h40,  6, 8'h22};
        vecs[8]  = '{1'b1, 1'b0, 3'd0, 8'h77, 8'hFE, 1'b1, 8'h00, -1, 8'h00};
        vecs[9]  = '{1'b1, 1'b1, 3'd0, 8'h3C, 8'hFE, 1'b0, 8'h01,  0, 8'h77};
        vecs[10] = '{1'b1, 1'b1, 3'd0, 8'h3C, 8'hFF, 1'b1, 8'h01,  0, 8'h77};
        vecs[11] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'hFF,  5, 8'h3C};
        vecs[12] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'hFF,  0, 8'h3C};
        vecs[13] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00,  0, 8'h3C};

        // NOTE: bench inputs are driven with blocking assignments #1 after the
        // rising edge, so the DUT never sees them change at its sampling edge.
        rst_n = 1'b0;
        m_if.in = '0; m_if.ctrl = '0; m_if.bcast = 1'b0; m_if.in_valid = 1'b0; m_if.out_ready = '0;
        e_if.in = '0; e_if.ctrl = '0; e_if.bcast = 1'b0; e_if.in_valid = 1'b0; e_if.out_ready = '0;
        e_pend = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", m_if.out_valid, 8'h00);
        check("reset_out", m_if.out, 64'h0);
        check("reset_in_ready", m_if.in_ready, 1'b1);
        check("reset_busy", m_if.busy, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            m_if.in_valid  = vecs[i].in_valid;
            m_if.bcast     = vecs[i].bcast;
            m_if.ctrl      = vecs[i].ctrl;
            m_if.in        = vecs[i].data;
            m_if.out_ready = vecs[i].out_ready;
            @(negedge clk);
            check($sformatf("v%0d_in_ready", i), m_if.in_ready, vecs[i].exp_ready);
            check($sformatf("v%0d_out_valid", i), m_if.out_valid, vecs[i].exp_valid);
            check($sformatf("v%0d_busy", i), m_if.busy, |vecs[i].exp_valid);
            if (vecs[i].lane >= 0)
                check($sformatf("v%0d_lane%0d", i, vecs[i].lane),
                      m_if.out[vecs[i].lane*8 +: 8], vecs[i].lane_val);
        end

        // Channel 1 stalled while channel 7 streams at full rate.
        @(posedge clk); #1;
        m_if.in_valid = 1'b1; m_if.bcast = 1'b0; m_if.ctrl = 3'd1; m_if.in = 8'h5A;
        m_if.out_ready = 8'hFD;
        @(negedge clk);
        check("indep_load_ch1_ready", m_if.in_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            m_if.in_valid = (i < 4);
            m_if.ctrl     = 3'd7;
            m_if.in       = 8'hC0 + 8'(i);
            @(negedge clk);
            check($sformatf("indep%0d_busy", i), m_if.busy, 1'b1);
            check($sformatf("indep%0d_ch1_valid", i), m_if.out_valid[1], 1'b1);
            check($sformatf("indep%0d_ch1_data", i), m_if.out[15:8], 8'h5A);
            check($sformatf("indep%0d_ch7_valid", i), m_if.out_valid[7], (i >= 1 && i <= 4));
            if (i < 4) check($sformatf("indep%0d_in_ready", i), m_if.in_ready, 1'b1);
            if (i >= 1 && i <= 4)
                check($sformatf("indep%0d_ch7_data", i), m_if.out[63:56], 8'hC0 + 8'(i - 1));
        end
        @(posedge clk); #1;
        m_if.in_valid = 1'b0; m_if.out_ready = 8'hFF;
        @(negedge clk);
        check("indep_release_ch1_valid", m_if.out_valid[1], 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("indep_drained", m_if.out_valid, 8'h00);

        // Asynchronous reset with channels 2 and 5 holding undelivered words.
        @(posedge clk); #1;
        m_if.in_valid = 1'b1; m_if.ctrl = 3'd2; m_if.in = 8'hD2; m_if.out_ready = 8'h00;
        @(posedge clk); #1;
        m_if.ctrl = 3'd5; m_if.in = 8'hD5;
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_out_valid", m_if.out_valid, 8'h24);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", m_if.out_valid, 8'h00);
        check("async_reset_out", m_if.out, 64'h0);
        check("async_reset_in_ready", m_if.in_ready, 1'b1);
        check("async_reset_busy", m_if.busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_if.out_ready = 8'hFF;

        // Randomised S=1, T=1 run; the producer holds its word until accepted.
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            if (e_acc) e_pend = 1'b0;
            if (!e_pend && $urandom_range(0, 3) != 0) begin
                e_pend     = 1'b1;
                e_if.ctrl  = 1'($urandom_range(0, 1));
                e_if.in    = 1'($urandom_range(0, 1));
                e_if.bcast = ($urandom_range(0, 7) == 0);
            end
            e_if.in_valid  = e_pend;
            e_if.out_ready = 2'($urandom_range(0, 3));
        end

        @(posedge clk); #1;
        e_if.in_valid = 1'b0; e_if.out_ready = 2'b11; m_if.out_ready = 8'hFF;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("edge_drained_valid", e_if.out_valid, 2'b00);
        for (int k = 0; k < 2; k++) check($sformatf("e_sb_left_ch%0d", k), eq[k].size(), 0);
        for (int k = 0; k < 8; k++) check($sformatf("m_sb_left_ch%0d", k), mq[k].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
